riscv_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer for the RV32I ALU-only core.
- Owns the PC and the instruction register.
- Runs fetch from instruction memory via a strobe/ready handshake, hands the latched instruction to the decoder, checks legality from the decoder status, and issues the register-file write-enable pulse.
- Sits between instruction memory and the decoder / register-file / ALU datapath.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/riscv_perf_counters.sv | 35 +++
 rtl/riscv_ctrl_fsm.sv | 125 ++++++++++++
 tb/tb_riscv_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I ALU-only control sequencer: state encoding,
// opcode constants, reset instruction word and the legality helper.
package riscv_pkg;

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] EXECUTE = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;
  localparam logic [2:0] TRAP    = 3'd5;

  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Only uncompressed encodings that the decoder flags as ALU ops are executable.
  function automatic logic is_legal(input logic [31:0] ir, input logic is_alu);
    return (ir[1:0] == 2'b11) && is_alu;
  endfunction

endpackage

// File: rtl/riscv_perf_counters.sv
// Cycle and retired-instruction counters for the control sequencer.
// Only built when RV_CTRL_PERF_EN is defined.
`ifdef RV_CTRL_PERF_EN
module riscv_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_cycle,
  input  logic        count_instret,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] cycle_r;
  logic [31:0] instret_r;

  // Wrapping event counters, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r   <= 32'h0;
      instret_r <= 32'h0;
    end else begin
      if (count_cycle) begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (count_instret) begin
        instret_r <= instret_r + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_r;
  assign instret_cnt = instret_r;

endmodule
`endif

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer owning PC and instruction register.
// Optional performance counters are enabled with the RV_CTRL_PERF_EN macro.
module riscv_ctrl_fsm
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr,
  input  logic        dec_is_alu,
  input  logic        dec_wb_en,
  output logic        rf_wr_en,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap,
  output logic [31:0] pc,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        mem_rstrb_s;
  logic        rf_wr_en_s;
  logic        halted_s;
  logic        trap_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // PC and instruction register; low PC bits are forced to zero so fetches stay word aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= {RESET_ADDR[31:2], 2'b00};
      instr_r <= NOP_INSTR;
    end else begin
      if (state_r == WAIT && mem_ready) begin
        instr_r <= mem_rdata;
      end
      if (state_r == EXECUTE) begin
        pc_r <= pc_r + 32'd4;
      end
    end
  end

  // Next-state logic; unused encodings fall into TRAP.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FETCH: begin
        if (halt_req) state_s = HALT;
        else          state_s = WAIT;
      end
      WAIT: begin
        if (mem_ready) state_s = DECODE;
        else           state_s = WAIT;
      end
      DECODE: begin
        if (is_legal(instr_r, dec_is_alu)) state_s = EXECUTE;
        else                               state_s = TRAP;
      end
      EXECUTE: state_s = FETCH;
      HALT: begin
        if (halt_req) state_s = HALT;
        else          state_s = FETCH;
      end
      TRAP:    state_s = TRAP;
      default: state_s = TRAP;
    endcase
  end

  // Control outputs decoded from state; all held low while reset is asserted.
  always_comb begin
    mem_rstrb_s = 1'b0;
    rf_wr_en_s  = 1'b0;
    halted_s    = 1'b0;
    trap_s      = 1'b0;
    case (state_r)
      FETCH:   mem_rstrb_s = ~halt_req & ~reset;
      WAIT:    mem_rstrb_s = 1'b0;
      DECODE:  mem_rstrb_s = 1'b0;
      EXECUTE: rf_wr_en_s  = dec_wb_en & ~reset;
      HALT:    halted_s    = ~reset;
      TRAP:    trap_s      = ~reset;
      default: trap_s      = ~reset;
    endcase
  end

  assign mem_addr  = pc_r;
  assign pc        = pc_r;
  assign instr     = instr_r;
  assign mem_rstrb = mem_rstrb_s;
  assign rf_wr_en  = rf_wr_en_s;
  assign halted    = halted_s;
  assign trap      = trap_s;

`ifdef RV_CTRL_PERF_EN
  riscv_perf_counters u_perf (
    .clk           (clk),
    .reset         (reset),
    .count_cycle   ((state_r != HALT) && (state_r != TRAP)),
    .count_instret (state_r == EXECUTE),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );
`else
  assign cycle_cnt   = 32'h0;
  assign instret_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Self-checking bench for riscv_ctrl_fsm: instruction memory responder, decoder
// model and a write-back scoreboard, plus a second instance reset at 32'hFFFF_FFFC.
`timescale 1ns/1ps
module tb_riscv_ctrl_fsm;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } wb_t;

`ifdef RV_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_rdata, instr, pc, cycle_cnt, instret_cnt;
  logic        mem_rstrb, mem_ready, dec_is_alu, dec_wb_en, rf_wr_en;
  logic        halt_req, halted, trap;

  logic [31:0] w_mem_addr, w_instr, w_pc, w_cycle_cnt, w_instret_cnt;
  logic        w_mem_rstrb, w_dec_is_alu, w_dec_wb_en, w_rf_wr_en, w_halted, w_trap;
  logic [31:0] w_mem_rdata = 32'h0050_0093;
  logic        w_mem_ready = 1'b1;
  logic        w_halt_req  = 1'b0;

  logic [31:0] prog [0:7];
  int          mem_delay;
  bit          spur;
  wb_t         sb [$];
  int          n_checks;
  int          n_pass;
  int          cyc;

  always #5 clk = ~clk;

  function automatic logic alu_op(input logic [31:0] w);
    return (w[6:2] == OPC_OP_IMM) || (w[6:2] == OPC_OP);
  endfunction

  assign dec_is_alu   = alu_op(instr);
  assign dec_wb_en    = dec_is_alu;
  assign w_dec_is_alu = alu_op(w_instr);
  assign w_dec_wb_en  = w_dec_is_alu;

  riscv_ctrl_fsm dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
    .dec_is_alu(dec_is_alu), .dec_wb_en(dec_wb_en), .rf_wr_en(rf_wr_en),
    .halt_req(halt_req), .halted(halted), .trap(trap), .pc(pc),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  riscv_ctrl_fsm #(.RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .mem_addr(w_mem_addr), .mem_rstrb(w_mem_rstrb),
    .mem_rdata(w_mem_rdata), .mem_ready(w_mem_ready), .instr(w_instr),
    .dec_is_alu(w_dec_is_alu), .dec_wb_en(w_dec_wb_en), .rf_wr_en(w_rf_wr_en),
    .halt_req(w_halt_req), .halted(w_halted), .trap(w_trap), .pc(w_pc),
    .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
  );

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset    = 1'b1;
    halt_req = 1'b0;
    @(negedge clk);
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, NOP_INSTR);
    check32("rst_ctrl", {28'd0, mem_rstrb, rf_wr_en, halted, trap}, 32'h0);
    check32("rst_cycle_cnt", cycle_cnt, 32'h0);
    check32("rst_instret_cnt", instret_cnt, 32'h0);
    check32("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = -1;
  endtask

  // Memory responder: answers each strobe after mem_delay extra wait cycles and
  // records the write-back that the fetched word should produce.
  initial begin
    logic [31:0] w;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_rstrb) begin
        w = prog[mem_addr[4:2]];
        if (w[1:0] == 2'b11 && alu_op(w)) sb.push_back({mem_addr, w});
        if (spur) begin
          mem_ready = 1'b1;
          mem_rdata = 32'hFFFF_FFFF;
        end
        repeat (mem_delay + 1) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = w;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  // Write-back monitor: every rf_wr_en pulse must match the oldest expected entry.
  always @(negedge clk) begin
    wb_t e;
    if (!reset && rf_wr_en) begin
      if (sb.size() == 0) begin
        check32("wb_unexpected", {31'd0, rf_wr_en}, 32'd0);
      end else begin
        e = sb.pop_front();
        check32("wb_pc", pc, e.addr);
        check32("wb_instr", instr, e.word);
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    reset     = 1'b1;
    halt_req  = 1'b0;
    mem_delay = 0;
    spur      = 1'b1;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0030_8213;
    for (int i = 4; i < 8; i++) prog[i] = 32'h0000_0013;

    // Zero-wait run of three instructions with a spurious ready during FETCH.
    reset_dut();
    goto(0);
    check32("c0_rstrb", {31'd0, mem_rstrb}, 32'd1);
    check32("c0_addr", mem_addr, 32'h0);
    check32("c0_instr", instr, NOP_INSTR);
    check32("c0_wrap_addr", w_mem_addr, 32'hFFFF_FFFC);
    goto(1);
    check32("c1_rstrb", {31'd0, mem_rstrb}, 32'd0);
    goto(3);
    check32("c3_wr_en", {31'd0, rf_wr_en}, 32'd1);
    goto(4);
    check32("c4_pc", pc, 32'h4);
    check32("c4_addr", mem_addr, 32'h4);
    check32("c4_rstrb", {31'd0, mem_rstrb}, 32'd1);
    check32("wrap_pc", w_pc, 32'h0);
    check32("wrap_addr", w_mem_addr, 32'h0);
    goto(11);
    check32("c11_pc", pc, 32'h8);
    halt_req = 1'b1;
    goto(12);
    check32("c12_pc", pc, 32'hC);
    check32("c12_rstrb", {31'd0, mem_rstrb}, 32'd0);
    check32("c12_cycle_cnt", cycle_cnt, PERF ? 32'd12 : 32'd0);
    check32("c12_instret_cnt", instret_cnt, PERF ? 32'd3 : 32'd0);
    goto(13);
    check32("halt_flags", {30'd0, halted, trap}, 32'd2);
    goto(15);
    check32("halt_pc", pc, 32'hC);
    check32("halt_rstrb", {31'd0, mem_rstrb}, 32'd0);
    check32("halt_cycle_cnt", cycle_cnt, PERF ? 32'd13 : 32'd0);
    halt_req  = 1'b0;
    spur      = 1'b0;
    mem_delay = 3;

    // Resume fetch at 12 with three extra memory wait cycles.
    goto(16);
    check32("resume_halted", {31'd0, halted}, 32'd0);
    check32("resume_rstrb", {31'd0, mem_rstrb}, 32'd1);
    check32("resume_addr", mem_addr, 32'hC);
    for (int k = 17; k <= 20; k++) begin
      goto(k);
      check32("wait_instr", instr, prog[2]);
      check32("wait_ctrl", {30'd0, mem_rstrb, rf_wr_en}, 32'd0);
    end
    goto(21);
    check32("latched_instr", instr, prog[3]);
    check32("decode_wr_en", {31'd0, rf_wr_en}, 32'd0);
    goto(22);
    check32("slow_wr_en", {31'd0, rf_wr_en}, 32'd1);
    halt_req = 1'b1;
    goto(23);
    check32("slow_pc", pc, 32'h10);
    check32("slow_rstrb", {31'd0, mem_rstrb}, 32'd0);

    // Illegal JAL traps and sticks until reset.
    mem_delay = 0;
    prog[0]   = 32'h0000_006F;
    reset_dut();
    goto(0);
    check32("pre_trap", {30'd0, halted, trap}, 32'd0);
    goto(3);
    check32("trap_flags", {30'd0, halted, trap}, 32'd1);
    check32("trap_pc", pc, 32'h0);
    check32("trap_instr", instr, 32'h0000_006F);
    goto(6);
    check32("trap_sticky", {31'd0, trap}, 32'd1);
    check32("trap_hold_pc", pc, 32'h0);
    check32("trap_rstrb", {31'd0, mem_rstrb}, 32'd0);
    check32("trap_cycle_cnt", cycle_cnt, PERF ? 32'd3 : 32'd0);
    check32("trap_instret_cnt", instret_cnt, 32'd0);

    // Reset clears the trap and restarts from address 0.
    prog[0] = 32'h0050_0093;
    reset_dut();
    goto(0);
    check32("post_trap_flag", {31'd0, trap}, 32'd0);
    check32("post_trap_pc", pc, 32'h0);
    check32("post_trap_rstrb", {31'd0, mem_rstrb}, 32'd1);
    goto(3);
    halt_req = 1'b1;
    goto(4);
    check32("post_trap_pc4", pc, 32'h4);
    goto(5);
    check32("post_trap_halted", {31'd0, halted}, 32'd1);
    check32("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
